regbank_wr_arbiter: RTL and testbench
=====================================

Name: regbank_wr_arbiter

Overview:
Arbitrates one shared write port of a bank of NUM_REGS enable-flop registers (DATA_SIZE bits each) between two requesters, e.g. writeback and the exception/EPC path. Every cycle it picks at most one requester with round-robin fairness, returns a one-cycle grant, and drives registered one-hot write enables and write data to the register bank. The register bank loads wr_data into register i on the clock edge where wr_en[i] is high.

Parameters:
DATA_SIZE, 16, width of each register and of the data paths
NUM_REGS, 8, number of registers in the bank (2..2^ADDR_W)
ADDR_W, 3, width of the requester address fields

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  asynchronous, active-low reset: state clears immediately while rst=0
req0  input  1  requester 0 write request
addr0  input  ADDR_W  requester 0 target register
data0  input  DATA_SIZE  requester 0 write data
req1  input  1  requester 1 write request
addr1  input  ADDR_W  requester 1 target register
data1  input  DATA_SIZE  requester 1 write data
gnt0  output  1  one-cycle grant to requester 0
gnt1  output  1  one-cycle grant to requester 1
wr_en  output  NUM_REGS  one-hot register-bank load enables
wr_data  output  DATA_SIZE  data for the enabled register
addr_err  output  1  one-cycle pulse: granted address is out of range (>= NUM_REGS)

Behaviour:
- State: prio (1 bit, the preferred requester) and registered outputs gnt0, gnt1, wr_en, wr_data, addr_err.
- Reset (rst=0, asynchronous): gnt0=0, gnt1=0, wr_en=0, wr_data=0, addr_err=0, prio=0. The first rising edge after rst returns to 1 performs normal arbitration.
- Eligibility in cycle N: elig_k = req_k AND NOT gnt_k. A requester granted in the previous cycle cannot win again in the cycle its grant is visible.
  - This blocks a double write when req_k is still high during its grant cycle.
- Winner:
  - Only one requester eligible: that requester wins.
  - Both eligible: requester prio wins.
  - Neither eligible: no winner.
- At the rising edge ending cycle N, with winner k:
  - gnt_k=1 and the other grant =0.
  - wr_data=data_k.
  - If addr_k < NUM_REGS: wr_en=one-hot(addr_k), addr_err=0.
  - If addr_k >= NUM_REGS: wr_en=0, addr_err=1. The grant is still issued so the requester does not hang.
  - prio becomes the other requester (1-k).
- At the rising edge ending cycle N with no winner: gnt0=gnt1=0, wr_en=0, addr_err=0, wr_data holds its value, prio holds.
- Latency: request sampled in cycle N gives grant and wr_en in cycle N+1. The register bank updates at the end of cycle N+1.
- Requester protocol:
  - Hold req, addr and data stable until the grant is seen.
  - The request is consumed in the cycle gnt_k=1.
  - Asserting req_k again in that same cycle is ignored (masked). If req_k is still high in the following cycle, it is a new request.
- Throughput:
  - Single requester: one write every 2 cycles.
  - Both requesting continuously: alternating grants 0,1,0,1..., one write per cycle.
- Invariants: gnt0 AND gnt1 is never true. wr_en has at most one bit set. wr_en is nonzero only when a grant is high.
- Same address from both requesters: writes are serialized in grant order. The later write wins in the register.
- Reset mid-operation: an asserted grant or wr_en drops to 0 immediately. A request pending at reset is re-arbitrated after reset with prio=0.

Test Plan:
- Reset: hold rst=0 with req0=req1=1 -> gnt0=gnt1=0, wr_en=0, wr_data=0. After rst=1 the first edge gives gnt0=1 (prio=0).
- Single request: req0=1, addr0=3, data0=16'hBEEF for 1 cycle -> next cycle gnt0=1, wr_en=8'b0000_1000, wr_data=16'hBEEF. The following cycle gnt0=0, wr_en=0.
- Contention: req0=req1=1 held, addr0=1, addr1=2 -> grants alternate gnt0, gnt1, gnt0, ... with wr_en alternating 8'h02 / 8'h04 every cycle. Never both grants high.
- Masking: req1=1 held continuously, req0=0 -> gnt1 pulses every other cycle (1,0,1,0), wr_en=8'h00 in the off cycles.
- Out-of-range address: NUM_REGS=6, req0=1, addr0=7 -> gnt0=1, addr_err=1, wr_en=0 for one cycle.
- Async reset mid-grant: drop rst=0 between clock edges while gnt1=1, wr_en=8'h10 -> both go to 0 before the next edge. After release with req0=req1=1, gnt0 wins first.

Source files
------------

// File: rtl/regbank_wr_arbiter.sv
// Two-requester round-robin arbiter for the single write port of an enable-flop register bank.
// Grants, one-hot write enables, write data and an address-error pulse are all registered.
module regbank_wr_arbiter #(
  parameter int DATA_SIZE = 16,
  parameter int NUM_REGS  = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [DATA_SIZE-1:0] data0,
  input  logic                 req1,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [DATA_SIZE-1:0] data1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [NUM_REGS-1:0]  wr_en,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 addr_err
);

  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NUM_REGS);

  logic                 prio_q, prio_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic [NUM_REGS-1:0]  wr_en_q, wr_en_d;
  logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic                 addr_err_q, addr_err_d;

  logic                 elig0, elig1;
  logic                 win0, win1;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_SIZE-1:0] sel_data;
  logic                 addr_ok;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

  // A requester whose grant is visible this cycle is masked so a held req cannot write twice.
  always_comb begin
    elig0    = req0 & ~gnt0_q;
    elig1    = req1 & ~gnt1_q;
    win0     = elig0 & (~elig1 | ~prio_q);
    win1     = elig1 & (~elig0 | prio_q);
    sel_addr = win1 ? addr1 : addr0;
    sel_data = win1 ? data1 : data0;
    addr_ok  = {1'b0, sel_addr} < NREGS_W;
  end

  always_comb begin
    gnt0_d     = win0;
    gnt1_d     = win1;
    wr_en_d    = '0;
    addr_err_d = 1'b0;
    wr_data_d  = wr_data_q;
    prio_d     = prio_q;
    if (win0 | win1) begin
      wr_data_d = sel_data;
      prio_d    = win0;
      // Out-of-range targets still get their grant so the requester is released.
      if (addr_ok) begin
        wr_en_d = onehot(sel_addr);
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  // Stage boundary: registered grant / write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q     <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter: a per-cycle request model pushes expected outputs,
// a monitor pops and compares them one edge later.
module tb_regbank_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 6;
  localparam int AW = 3;

  typedef struct packed {
    logic          g0;
    logic          g1;
    logic          err;
    logic [NR-1:0] we;
    logic [DW-1:0] wd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1, addr_err;
  logic [NR-1:0] wr_en;
  logic [DW-1:0] wr_data;

  regbank_wr_arbiter #(.DATA_SIZE(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .wr_en(wr_en), .wr_data(wr_data), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: preferred requester, grants currently visible, last written data.
  bit          m_prio = 1'b0;
  bit          m_g0 = 1'b0, m_g1 = 1'b0;
  logic [DW-1:0] m_wd = '0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
  endfunction

  // Decide who gets the write port at the coming edge, from the request/grant rules.
  function automatic void step();
    exp_t e;
    int   win;
    int   a;
    bit   can0, can1;
    e = '0;
    if (!rst) begin
      m_prio = 1'b0;
      m_wd   = '0;
    end else begin
      can0 = req0 && !m_g0;
      can1 = req1 && !m_g1;
      if (can0 && can1) win = m_prio ? 1 : 0;
      else if (can0)    win = 0;
      else if (can1)    win = 1;
      else              win = -1;
      if (win >= 0) begin
        a    = (win == 1) ? int'(addr1) : int'(addr0);
        m_wd = (win == 1) ? data1 : data0;
        if (win == 0) e.g0 = 1'b1; else e.g1 = 1'b1;
        if (a < NR) e.we[a] = 1'b1;
        else        e.err   = 1'b1;
        m_prio = (win == 0);
      end
    end
    e.wd = m_wd;
    m_g0 = e.g0;
    m_g1 = e.g1;
    q.push_back(e);
  endfunction

  task automatic drive(input bit r, input bit q0, input int a0, input int d0,
                       input bit q1, input int a1, input int d1);
    @(negedge clk);
    rst   = r;
    req0  = q0;  addr0 = AW'(a0);  data0 = DW'(d0);
    req1  = q1;  addr1 = AW'(a1);  data1 = DW'(d1);
    step();
  endtask

  // Monitor: one expectation per edge, plus structural invariants.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("outputs{g0,g1,err,we,wd}", 64'({gnt0, gnt1, addr_err, wr_en, wr_data}), 64'(e));
      chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
      chk("wr_en_onehot0", 64'($onehot0(wr_en)), 64'd1);
      chk("wr_en_needs_gnt", 64'((|wr_en) & ~(gnt0 | gnt1)), 64'd0);
    end
  end

  bit          pend0, pend1;
  int          ra0, ra1, rd0, rd1;

  initial begin
    // Reset held with both requesters active, then released.
    drive(0, 1, 1, 'h1111, 1, 2, 'h2222);
    drive(0, 1, 1, 'h1111, 1, 2, 'h2222);
    drive(1, 1, 1, 'h1111, 1, 2, 'h2222);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Single request.
    drive(1, 1, 3, 'hBEEF, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Contention.
    repeat (6) drive(1, 1, 1, 'hAAAA, 1, 2, 'h5555);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Masking with req1 held.
    repeat (6) drive(1, 0, 0, 0, 1, 5, 'hC0DE);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Out-of-range targets (NR=6).
    drive(1, 1, 7, 'hDEAD, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 6, 'hF00D);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while gnt1 / wr_en[4] are high.
    drive(1, 0, 0, 0, 1, 4, 'hA5A5);
    @(negedge clk);
    chk("pre_rst{gnt1,wr_en}", 64'({gnt1, wr_en}), 64'({1'b1, 6'h10}));
    rst = 1'b0;
    #1;
    chk("async_rst{g0,g1,err,we}", 64'({gnt0, gnt1, addr_err, wr_en}), 64'd0);
    req0 = 1'b1; addr0 = 3'd2; data0 = 16'h0102;
    req1 = 1'b1; addr1 = 3'd3; data1 = 16'h0304;
    step();
    drive(0, 1, 2, 'h0102, 1, 3, 'h0304);
    drive(1, 1, 2, 'h0102, 1, 3, 'h0304);
    drive(1, 0, 0, 0, 1, 3, 'h0304);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);

    // Randomized requesters obeying the hold-until-grant protocol.
    pend0 = 1'b0; pend1 = 1'b0;
    ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
    repeat (600) begin
      if (m_g0) pend0 = 1'b0;
      if (m_g1) pend1 = 1'b0;
      if (!pend0 && ($urandom_range(0, 1) == 1)) begin
        pend0 = 1'b1; ra0 = int'($urandom_range(0, 7)); rd0 = int'($urandom_range(0, 65535));
      end
      if (!pend1 && ($urandom_range(0, 2) != 0)) begin
        pend1 = 1'b1; ra1 = int'($urandom_range(0, 7)); rd1 = int'($urandom_range(0, 65535));
      end
      drive(1, pend0, ra0, rd0, pend1, ra1, rd1);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
